// File: rtl/alu_arb_pkg.sv
// Shared widths, FSM state type and ALU function codes for the ALU arbiter.
package alu_arb_pkg;

    localparam int unsigned OP_W  = 8;
    localparam int unsigned FN_W  = 3;
    localparam int unsigned RES_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    localparam logic [FN_W-1:0] FN_ADD = 3'd0;
    localparam logic [FN_W-1:0] FN_SUB = 3'd1;
    localparam logic [FN_W-1:0] FN_AND = 3'd2;
    localparam logic [FN_W-1:0] FN_OR  = 3'd3;
    localparam logic [FN_W-1:0] FN_XOR = 3'd4;
    localparam logic [FN_W-1:0] FN_MUL = 3'd5;
    localparam logic [FN_W-1:0] FN_SHL = 3'd6;
    localparam logic [FN_W-1:0] FN_SHR = 3'd7;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    always_comb begin
        int unsigned cand;
        cand  = 0;
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr_ptr) + k) % NUM_REQ;
            if (!any && req[cand[IDX_W-1:0]]) begin
                any   = 1'b1;
                index = cand[IDX_W-1:0];
                grant = NUM_REQ'(1) << cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters, one op in flight.
// Optional WAIT timeout enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*OP_W-1:0] req_op1,
    input  logic [NUM_REQ*OP_W-1:0] req_op2,
    input  logic [NUM_REQ*FN_W-1:0] req_fn,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [RES_W-1:0]        rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    alu_enable,
    output logic [OP_W-1:0]         alu_op1,
    output logic [OP_W-1:0]         alu_op2,
    output logic [FN_W-1:0]         alu_fn,
    input  logic [RES_W-1:0]        alu_out,
    input  logic                    alu_valid
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [OP_W-1:0]    op1_q, op1_d;
    logic [OP_W-1:0]    op2_q, op2_d;
    logic [FN_W-1:0]    fn_q, fn_d;
    logic [RES_W-1:0]   res_q, res_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               timeout;
    logic               op_live;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_grant),
        .index  (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        grant_d  = grant_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        fn_d     = fn_q;
        res_d    = res_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    idx_d   = pick_idx;
                    grant_d = pick_grant;
                    op1_d   = req_op1[pick_idx*OP_W +: OP_W];
                    op2_d   = req_op2[pick_idx*OP_W +: OP_W];
                    fn_d    = req_fn[pick_idx*FN_W +: FN_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // A result arriving on the timeout cycle still takes priority.
                if (alu_valid) begin
                    res_d   = alu_out;
                    state_d = RESP;
                end else if (timeout) begin
                    res_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                rr_ptr_d = (32'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            grant_q  <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            fn_q     <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            grant_q  <= grant_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            fn_q     <= fn_d;
            res_q    <= res_d;
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    assign timeout = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // WAIT is left only on alu_valid or timeout, so the last WAIT sample decides the error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
            err_q      <= ~alu_valid;
        end else begin
            wait_cnt_q <= '0;
        end
    end

    assign rsp_err = (state_q == RESP) & err_q;
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign op_live    = (state_q == ISSUE) || (state_q == WAIT);
    assign busy       = (state_q != IDLE);
    assign alu_enable = (state_q == ISSUE);
    assign req_ready  = alu_enable ? grant_q : '0;
    assign rsp_valid  = (state_q == RESP) ? grant_q : '0;
    assign rsp_data   = (state_q == RESP) ? res_q : '0;
    assign alu_op1    = op_live ? op1_q : '0;
    assign alu_op2    = op_live ? op2_q : '0;
    assign alu_fn     = op_live ? fn_q : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, scoreboard and corner-case sequences.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*8-1:0] req_op1, req_op2;
    logic [N*3-1:0] req_fn;
    logic [N-1:0]  req_ready, rsp_valid;
    logic [15:0]   rsp_data;
    logic          rsp_err, busy, alu_enable;
    logic [7:0]    alu_op1, alu_op2;
    logic [2:0]    alu_fn;
    logic [15:0]   alu_out;
    logic          alu_valid;

    logic        mdl_valid = 1'b0, frc_valid = 1'b0;
    logic [15:0] mdl_out = '0, frc_out = '0;
    int          alu_lat = 1, alu_cnt = 0;
    logic        alu_mute = 1'b0;
    logic [15:0] alu_res = '0;

    assign alu_valid = mdl_valid | frc_valid;
    assign alu_out   = frc_valid ? frc_out : mdl_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [N-1:0] onehot;
        logic [15:0]  data;
        logic         err;
    } rsp_t;
    rsp_t sb_q[$];

    typedef struct {
        int          idx;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  f;
        int          lat;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[8];

    alu_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_fn     (req_fn),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .alu_enable (alu_enable),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_fn     (alu_fn),
        .alu_out    (alu_out),
        .alu_valid  (alu_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_model(logic [7:0] a, logic [7:0] b, logic [2:0] f);
        logic [15:0] x, y;
        x = {8'h00, a};
        y = {8'h00, b};
        case (f)
            FN_ADD:  return x + y;
            FN_SUB:  return x - y;
            FN_AND:  return x & y;
            FN_OR:   return x | y;
            FN_XOR:  return x ^ y;
            FN_MUL:  return x * y;
            FN_SHL:  return x << b[2:0];
            default: return x >> b[2:0];
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({req_ready, rsp_valid, rsp_data, rsp_err, busy, alu_enable,
                    alu_op1, alu_op2, alu_fn});
    endfunction

    // ALU model: answers L cycles after the enable cycle.
    always @(negedge clk) begin
        mdl_valid = 1'b0;
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                mdl_valid = 1'b1;
                mdl_out   = alu_res;
            end
        end
        if (alu_enable && !alu_mute) begin
            alu_cnt = alu_lat;
            alu_res = alu_model(alu_op1, alu_op2, alu_fn);
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && rsp_valid != '0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(e.onehot));
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    task automatic drive_req(input int idx, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] f);
        req_valid[idx]      = 1'b1;
        req_op1[idx*8 +: 8] = a;
        req_op2[idx*8 +: 8] = b;
        req_fn[idx*3 +: 3]  = f;
    endtask

    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] f, input int lat, input logic [15:0] exp,
                          input logic exp_err, input int exp_n);
        int n;
        alu_lat = lat;
        @(negedge clk);
        drive_req(idx, a, b, f);
        sb_q.push_back('{onehot: N'(1) << idx, data: exp, err: exp_err});
        @(negedge clk);
        check("req_ready", 64'(req_ready), 64'(N'(1) << idx));
        check("alu_enable", 64'(alu_enable), 64'(1));
        check("alu_operands", 64'({alu_op1, alu_op2, alu_fn}), 64'({a, b, f}));
        req_valid[idx] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid == '0 && n < 200);
        check("rsp_latency", 64'(n), 64'(exp_n));
        @(negedge clk);
        check("idle_after_op", all_outputs(), 64'(0));
    endtask

    // Two simultaneous requesters; `first` must be served before `second`.
    task automatic race_pair(input int first, input int second);
        int n, got;
        alu_lat = 2;
        @(negedge clk);
        drive_req(first, 8'(32'h20 + first), 8'h03, FN_ADD);
        drive_req(second, 8'(32'h20 + second), 8'h03, FN_ADD);
        sb_q.push_back('{onehot: N'(1) << first, data: 16'(32'h23 + first), err: 1'b0});
        sb_q.push_back('{onehot: N'(1) << second, data: 16'(32'h23 + second), err: 1'b0});
        n   = 0;
        got = 0;
        while (got < 2 && n < 200) begin
            @(negedge clk);
            n++;
            req_valid = req_valid & ~req_ready;
            if (rsp_valid != '0) got++;
        end
        check("pair_done", 64'(got), 64'(2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, got;
        vecs[0] = '{0, 8'h12, 8'h34, FN_ADD, 2, 16'h0046};
        vecs[1] = '{1, 8'hF0, 8'h20, FN_ADD, 1, 16'h0110};
        vecs[2] = '{2, 8'h50, 8'h10, FN_SUB, 3, 16'h0040};
        vecs[3] = '{3, 8'hFF, 8'hFF, FN_MUL, 1, 16'hFE01};
        vecs[4] = '{1, 8'hCC, 8'hAA, FN_AND, 4, 16'h0088};
        vecs[5] = '{2, 8'hCC, 8'hAA, FN_XOR, 2, 16'h0066};
        vecs[6] = '{3, 8'h81, 8'h01, FN_SHL, 1, 16'h0102};
        vecs[7] = '{0, 8'h80, 8'h03, FN_SHR, 2, 16'h0010};

        rst       = 1'b1;
        req_valid = '0;
        req_op1   = '0;
        req_op2   = '0;
        req_fn    = '0;
        #1;
        check("reset_outputs", all_outputs(), 64'(0));

        // Contention: all requesters held valid out of reset.
        alu_lat = 1;
        for (int i = 0; i < int'(N); i++)
            drive_req(i, 8'(32'h10 * (i + 1)), 8'(i + 1), FN_ADD);
        for (int k = 0; k < 5; k++)
            sb_q.push_back('{onehot: N'(1) << (k % 4), data: 16'(32'h11 * ((k % 4) + 1)),
                             err: 1'b0});
        @(negedge clk);
        check("reset_ignores_req", all_outputs(), 64'(0));
        rst = 1'b0;
        n   = 0;
        got = 0;
        while (got < 5 && n < 400) begin
            @(negedge clk);
            n++;
            if (rsp_valid != '0) got++;
            if (got == 5) req_valid = '0;
        end
        check("contention_done", 64'(got), 64'(5));
        check("contention_cycles", 64'(n), 64'(19));

        foreach (vecs[i])
            run_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].lat, vecs[i].exp,
                   1'b0, vecs[i].lat + 1);

        // rr_ptr=2 after serving requester 1; then 3 must beat 1.
        run_op(1, 8'h01, 8'h01, FN_ADD, 1, 16'h0002, 1'b0, 2);
        race_pair(3, 1);

        // Stale ALU result while idle.
        @(negedge clk);
        frc_valid = 1'b1;
        frc_out   = 16'hBEEF;
        @(negedge clk);
        frc_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("stale_idle", all_outputs(), 64'(0));
        run_op(0, 8'h05, 8'h07, FN_ADD, 1, 16'h000C, 1'b0, 2);

        // Reset while waiting; rr_ptr was 2 beforehand.
        run_op(1, 8'h02, 8'h02, FN_ADD, 1, 16'h0004, 1'b0, 2);
        alu_mute = 1'b1;
        @(negedge clk);
        drive_req(2, 8'h33, 8'h44, FN_ADD);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[2] && n < 50);
        check("midop_ready", 64'(req_ready), 64'(4'b0100));
        req_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        check("midop_wait", 64'({busy, alu_enable, alu_op1}), 64'({1'b1, 1'b0, 8'h33}));
        #2 rst = 1'b1;
        #1 check("midop_reset_outputs", all_outputs(), 64'(0));
        @(negedge clk);
        rst       = 1'b0;
        frc_valid = 1'b1;
        frc_out   = 16'h1234;
        @(negedge clk);
        frc_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_idle", all_outputs(), 64'(0));
        alu_mute = 1'b0;
        race_pair(0, 3);

`ifdef ALU_ARB_TIMEOUT_EN
        alu_mute = 1'b1;
        run_op(2, 8'h11, 8'h22, FN_ADD, 1, 16'h0000, 1'b1, TO + 1);
        alu_mute = 1'b0;
        run_op(3, 8'h40, 8'h02, FN_ADD, TO, 16'h0042, 1'b0, TO + 1);
        run_op(0, 8'h09, 8'h03, FN_MUL, 2, 16'h001B, 1'b0, 3);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin controller that shares the single 8-bit ALU among NUM_REQ requesters. It accepts one operation at a time and drives the ALU's enable/op1/op2/fn inputs. It waits for the ALU's valid, then returns the 16-bit result to the requester that issued it. It sits between the requester blocks and the ALU interface, and is the only driver of the ALU inputs.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before abort (used only with ALU_ARB_TIMEOUT_EN)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_op1  in  NUM_REQ*8  packed operand 1; requester i uses bits [8i+7:8i]
- req_op2  in  NUM_REQ*8  packed operand 2
- req_fn  in  NUM_REQ*3  packed function code
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- rsp_valid  out  NUM_REQ  one-hot result pulse
- rsp_data  out  16  result, shared by all requesters; qualified by rsp_valid
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- busy  out  1  high in every state except IDLE
- alu_enable  out  1  to ALU enable
- alu_op1 / alu_op2  out  8  to ALU operands
- alu_fn  out  3  to ALU function select
- alu_out  in  16  from ALU result
- alu_valid  in  1  from ALU result valid

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE
  - If any req_valid is high, pick a winner round-robin, starting the search at rr_ptr and wrapping.
  - Latch the winner's op1/op2/fn and index, then go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE (exactly 1 cycle)
  - alu_enable=1 and req_ready[winner]=1; the valid/ready transfer completes in this cycle.
  - alu_op1/op2/fn drive the latched values; they are held stable in ISSUE and WAIT and are 0 otherwise.
  - Go to WAIT.
- WAIT
  - alu_valid is sampled only in this state. On alu_valid=1, capture alu_out and go to RESP.
- RESP (exactly 1 cycle)
  - rsp_valid[winner]=1, rsp_data=captured result.
  - rr_ptr becomes (winner+1) mod NUM_REQ. Go to IDLE.
- Requester contract: hold req_valid and operands stable until req_ready; deassertion before that is permitted. The arbiter latches in IDLE, so a later change does not affect an accepted op.
- alu_valid in IDLE, ISSUE or RESP is ignored. This covers stale results after a reset.
- Reset values: state=IDLE, rr_ptr=0, and every output is 0, including rsp_data, rsp_err and the alu_* outputs.
- Reset mid-operation drops the in-flight op. No rsp_valid is produced for it.

## Timing
- Requests are accepted only in IDLE, so there is at most one op in flight.
- Request seen in IDLE at cycle T → req_ready and alu_enable at T+1.
- ALU returns alu_valid at T+1+L, where L≥1.
- rsp_valid at T+2+L.
- Next IDLE at T+3+L. Back-to-back throughput is one op per L+3 cycles.
- With a single requester held constantly valid, every grant goes to that requester; no bubble beyond the IDLE cycle.
- Simultaneous requests: the lowest index at or after rr_ptr wins. Every requester is served within NUM_REQ grants.

## Configuration
- ALU_ARB_TIMEOUT_EN defined:
  - A WAIT cycle counter runs; it is cleared on entry to WAIT.
  - After TIMEOUT_CYCLES WAIT cycles without alu_valid, go to RESP with rsp_err=1 and rsp_data=16'h0000.
  - An alu_valid arriving in the same cycle as the timeout wins: normal result, rsp_err=0.
- ALU_ARB_TIMEOUT_EN undefined: no counter, rsp_err tied to 0, WAIT waits indefinitely.

## Structure
- alu_arb_pkg:
  - widths OP_W=8, FN_W=3, RES_W=16
  - state enum arb_state_t {IDLE, ISSUE, WAIT, RESP}
  - ALU function code constants
- Sub-module rr_picker: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, index, any.
- Top level: FSM, operand/result registers, timeout counter.

## Test plan
- Single op: req 0 with op1=8'h12, op2=8'h34, fn=3'd0, ALU L=2 → req_ready[0] at T+1, rsp_valid[0] at T+4, rsp_data=16'h0046.
- Contention: all 4 requesters valid from reset, held → grant order 0,1,2,3,0.
- Contention, mid-stream: requesters 1 and 3 valid with rr_ptr=2 → requester 3 first, then 1.
- Stale result: alu_valid pulsed in IDLE with alu_out=16'hBEEF → no rsp_valid; next real op returns its own result.
- Reset mid-op: rst asserted while in WAIT → all outputs 0 immediately, busy=0; alu_valid afterwards is ignored; rr_ptr=0.
- Timeout (ALU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): ALU never answers → rsp_valid[i] with rsp_err=1 and rsp_data=0 after 8 WAIT cycles; the next op completes normally.
